// File: rtl/lsu_dmem.sv
// Data-memory responder for the LSU: byte-addressed little-endian array, 1-cycle load latency.
// Define MISALIGN_CHK_EN to fault misaligned half/word accesses instead of force-aligning them.
module lsu_dmem #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             wr_en,
    input  logic [1:0]       wr_size,
    input  logic [31:0]      rd_addr,
    input  logic             rd_en,
    input  logic [1:0]       rd_size,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] fault_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [31:0] mem [DEPTH];

    // Forces the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        case (size)
            SZ_HALF: res = {lo[1], 1'b0};
            SZ_WORD: res = 2'b00;
            default: res = lo;
        endcase
        return res;
    endfunction

    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lo);
        logic f;
        f = (size == SZ_RSVD);
`ifdef MISALIGN_CHK_EN
        if (size == SZ_HALF && lo[0]) f = 1'b1;
        if (size == SZ_WORD && lo != 2'b00) f = 1'b1;
`else
        if (lo == 2'b11) f = f;
`endif
        return f;
    endfunction

    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [1:0]        wr_lo;
    logic [1:0]        rd_lo;
    logic              wr_fault;
    logic              rd_fault;
    logic              wr_fault_acc;
    logic              rd_fault_acc;
    logic              wr_go;
    logic [3:0]        wr_be;
    logic [31:0]       wr_lane;
    logic [31:0]       rd_word;
    logic [31:0]       rd_sel;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;
    logic              first_q;

    assign wr_idx = wr_addr[ADDR_W+1:2];
    assign rd_idx = rd_addr[ADDR_W+1:2];
    assign wr_lo  = align_lo(wr_size, wr_addr[1:0]);
    assign rd_lo  = align_lo(rd_size, rd_addr[1:0]);

    assign wr_fault     = is_fault(wr_size, wr_addr[1:0]);
    assign rd_fault     = is_fault(rd_size, rd_addr[1:0]);
    assign wr_fault_acc = wr_en & wr_fault;
    assign rd_fault_acc = rd_en & rd_fault;
    assign wr_go        = wr_en & ~stall & ~wr_fault;

    // Store byte enables and the store data replicated onto every candidate lane.
    always_comb begin
        wr_be   = 4'b0000;
        wr_lane = wr_data;
        case (wr_size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << wr_lo;
                wr_lane = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = wr_lo[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{wr_data[15:0]}};
            end
            SZ_WORD: begin
                wr_be   = 4'b1111;
                wr_lane = wr_data;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_lane = wr_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
            end
        end
    end

    // Combinational read of the old contents gives read-first behaviour on a same-edge store.
    assign rd_word = mem[rd_idx];

    always_comb begin
        rd_sel = 32'h0;
        case (rd_size)
            SZ_BYTE: rd_sel = {24'h0, rd_word[{rd_lo, 3'b000} +: 8]};
            SZ_HALF: rd_sel = {16'h0, rd_word[{rd_lo[1], 4'b0000} +: 16]};
            SZ_WORD: rd_sel = rd_word;
            default: rd_sel = 32'h0;
        endcase
    end

    assign cnt_sum  = {1'b0, fault_count}
                    + {{CNT_W{1'b0}}, wr_fault_acc}
                    + {{CNT_W{1'b0}}, rd_fault_acc};
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data     <= 32'h0;
            rd_valid    <= 1'b0;
            err         <= 1'b0;
            err_addr    <= 32'h0;
            fault_count <= '0;
            first_q     <= 1'b0;
        end else if (!stall) begin
            rd_valid    <= rd_en;
            err         <= wr_fault_acc | rd_fault_acc;
            fault_count <= cnt_next;
            if (rd_en) rd_data <= rd_fault ? 32'h0 : rd_sel;
            if ((wr_fault_acc | rd_fault_acc) && !first_q) begin
                first_q  <= 1'b1;
                err_addr <= wr_fault_acc ? wr_addr : rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed self-checking bench for lsu_dmem; follows MISALIGN_CHK_EN like the design.
module tb_lsu_dmem;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [1:0]  wr_size;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [1:0]  rd_size;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic [31:0] err_addr;
    logic [7:0]  fault_count;

    int n_vec;
    int n_err;

    lsu_dmem #(
        .ADDR_W(10),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_size    (wr_size),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_size    (rd_size),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err),
        .err_addr   (err_addr),
        .fault_count(fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of requests, then sample just after the edge.
    task automatic req(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [1:0] ws, input logic re, input logic [31:0] ra,
                       input logic [1:0] rs);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_size = ws;
        rd_en   = re;
        rd_addr = ra;
        rd_size = rs;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        stall   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_en   = 1'b0;
        wr_size = 2'b10;
        rd_addr = '0;
        rd_en   = 1'b0;
        rd_size = 2'b10;

        #12;
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        check_eq("rst_err", {31'h0, err}, 32'h0);
        check_eq("rst_err_addr", err_addr, 32'h0);
        check_eq("rst_fault_count", {24'h0, fault_count}, 32'h0);
        rst = 1'b1;
        tick();

        // Word store then load
        req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 2'b10);
        check_eq("no_load_valid", {31'h0, rd_valid}, 32'h0);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h10, 2'b10);
        check_eq("word_load", rd_data, 32'hDEADBEEF);
        check_eq("word_load_valid", {31'h0, rd_valid}, 32'h1);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 2'b10);
        check_eq("idle_valid_clear", {31'h0, rd_valid}, 32'h0);
        check_eq("idle_data_hold", rd_data, 32'hDEADBEEF);

        // Byte stores, half/byte loads
        req(1'b1, 32'h20, 32'hFFFFFF11, 2'b00, 1'b0, 32'h0, 2'b10);
        req(1'b1, 32'h21, 32'hFFFFFF22, 2'b00, 1'b0, 32'h0, 2'b10);
        req(1'b1, 32'h22, 32'hFFFFFF33, 2'b00, 1'b0, 32'h0, 2'b10);
        req(1'b1, 32'h23, 32'hFFFFFF44, 2'b00, 1'b0, 32'h0, 2'b10);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h22, 2'b01);
        check_eq("half_load_22", rd_data, 32'h00004433);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h21, 2'b00);
        check_eq("byte_load_21", rd_data, 32'h00000022);
        req(1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b1, 32'h20, 2'b10);
        check_eq("word_load_20", rd_data, 32'h44332211);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h20, 2'b10);
        check_eq("half_store_lanes", rd_data, 32'hBEEF2211);

        // Read-first on same-edge store/load
        req(1'b1, 32'h30, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0, 2'b10);
        req(1'b1, 32'h30, 32'h55555555, 2'b10, 1'b1, 32'h30, 2'b10);
        check_eq("read_first_old", rd_data, 32'hAAAAAAAA);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h30, 2'b10);
        check_eq("read_after_store", rd_data, 32'h55555555);

        // Stall: outputs frozen, held store lands once on release
        stall   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 32'h60;
        wr_data = 32'hCAFEF00D;
        wr_size = 2'b10;
        rd_en   = 1'b1;
        rd_addr = 32'h10;
        rd_size = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_rd_valid", {31'h0, rd_valid}, 32'h1);
            check_eq("stall_rd_data", rd_data, 32'h55555555);
        end
        stall = 1'b0;
        rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
        check_eq("release_valid_clear", {31'h0, rd_valid}, 32'h0);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h60, 2'b10);
        check_eq("stalled_store_written", rd_data, 32'hCAFEF00D);

        // Faults and misalignment
        req(1'b1, 32'h40, 32'h01020304, 2'b10, 1'b0, 32'h0, 2'b10);
        req(1'b1, 32'h50, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 2'b10);
`ifdef MISALIGN_CHK_EN
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h41, 2'b10);
        check_eq("mis_err", {31'h0, err}, 32'h1);
        check_eq("mis_rd_data", rd_data, 32'h0);
        check_eq("mis_rd_valid", {31'h0, rd_valid}, 32'h1);
        check_eq("mis_err_addr", err_addr, 32'h41);
        check_eq("mis_count", {24'h0, fault_count}, 32'h1);
        req(1'b1, 32'h50, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 2'b10);
        check_eq("rsvd_st_err", {31'h0, err}, 32'h1);
        check_eq("rsvd_st_count", {24'h0, fault_count}, 32'h2);
        check_eq("rsvd_st_err_addr", err_addr, 32'h41);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h50, 2'b10);
        check_eq("rsvd_st_no_write", rd_data, 32'h0BADF00D);
        check_eq("err_one_cycle", {31'h0, err}, 32'h0);
`else
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h41, 2'b10);
        check_eq("mis_aligned_word", rd_data, 32'h01020304);
        check_eq("mis_no_err", {31'h0, err}, 32'h0);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h43, 2'b01);
        check_eq("mis_aligned_half", rd_data, 32'h00000102);
        req(1'b1, 32'h50, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 2'b10);
        check_eq("rsvd_st_err", {31'h0, err}, 32'h1);
        check_eq("rsvd_st_count", {24'h0, fault_count}, 32'h1);
        check_eq("rsvd_st_err_addr", err_addr, 32'h50);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h50, 2'b10);
        check_eq("rsvd_st_no_write", rd_data, 32'h0BADF00D);
        check_eq("err_one_cycle", {31'h0, err}, 32'h0);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h58, 2'b11);
        check_eq("rsvd_ld_data", rd_data, 32'h0);
        check_eq("rsvd_ld_valid", {31'h0, rd_valid}, 32'h1);
        check_eq("rsvd_ld_count", {24'h0, fault_count}, 32'h2);
        check_eq("rsvd_ld_err_addr", err_addr, 32'h50);
`endif
        // Two faults on one edge count twice
        req(1'b1, 32'h70, 32'h0, 2'b11, 1'b1, 32'h74, 2'b11);
        check_eq("dbl_fault_count", {24'h0, fault_count}, 32'h4);
        check_eq("dbl_fault_err", {31'h0, err}, 32'h1);

        // Address aliasing modulo 4 KiB
        req(1'b1, 32'h0, 32'h12345678, 2'b10, 1'b0, 32'h0, 2'b10);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h1000, 2'b10);
        check_eq("alias_load", rd_data, 32'h12345678);
        req(1'b1, 32'h1004, 32'h9ABCDEF0, 2'b10, 1'b0, 32'h0, 2'b10);
        req(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 32'h4, 2'b10);
        check_eq("alias_store", rd_data, 32'h9ABCDEF0);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_rd_data", rd_data, 32'h0);
        check_eq("arst_rd_valid", {31'h0, rd_valid}, 32'h0);
        check_eq("arst_err", {31'h0, err}, 32'h0);
        check_eq("arst_err_addr", err_addr, 32'h0);
        check_eq("arst_fault_count", {24'h0, fault_count}, 32'h0);
        #3;
        rst = 1'b1;
        tick();

        // Saturation: 130 double faults reach all-ones; first fault's store address is kept
        for (int i = 0; i < 130; i++) begin
            req(1'b1, 32'h80 + 32'(i), 32'h0, 2'b11, 1'b1, 32'h84 + 32'(i), 2'b11);
        end
        check_eq("sat_count", {24'h0, fault_count}, 32'hFF);
        check_eq("first_err_addr_store", err_addr, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
